// File: rtl/synth_pkg.sv
// Shared types and constants for the voice synthesis datapath.
package synth_pkg;

  // Width of one shaped voice sample and of the shaper saw input.
  localparam int unsigned SAMPLE_W = 8;

  // Waveform select presented to wave_shaper; OFF yields a zero sample.
  typedef enum logic [1:0] {
    OFF    = 2'b00,
    SQUARE = 2'b01,
    SAW    = 2'b10,
    TRI    = 2'b11
  } wave_form_t;

  // Scheduler control states: waiting for a tick, or walking the voices.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/voice_scheduler_phase_bank.sv
// Per-voice phase accumulator storage: NV words, one combinational read
// port and one synchronous write port, cleared as a whole on reset.
module phase_bank #(
  parameter int unsigned NV      = 4,
  parameter int unsigned PHASE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [$clog2(NV)-1:0]  rd_addr_i,
  output logic [PHASE_W-1:0]     rd_data_o,
  input  logic                   wr_en_i,
  input  logic [$clog2(NV)-1:0]  wr_addr_i,
  input  logic [PHASE_W-1:0]     wr_data_i
);

  logic [PHASE_W-1:0] mem_q [NV];

  // Phase storage: clear all voices on reset, otherwise single-word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NV; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port is combinational so the scanned voice is available in its own cycle.
  always_comb begin
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/voice_scheduler.sv
// Time-shares one external wave_shaper among NV oscillator voices. Each
// sample_tick starts a scan of voices 0..NV-1 (one per clock); the shaped
// samples are summed and published as one mixed sample at the end of the scan.
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NV      = 4,
  parameter int unsigned PHASE_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic [NV-1:0]                    voice_en,
  input  logic [NV*PHASE_W-1:0]            voice_inc,
  input  logic [NV*2-1:0]                  voice_form,
  output logic [SAMPLE_W-1:0]              shaper_saw,
  output logic [1:0]                       shaper_form,
  input  logic [SAMPLE_W-1:0]              shaper_wave,
  output logic [SAMPLE_W+$clog2(NV)-1:0]   mix_out,
  output logic                             mix_valid,
  output logic                             busy,
  output logic                             overrun
);

  localparam int unsigned   VW     = $clog2(NV);
  localparam int unsigned   MW     = SAMPLE_W + VW;
  localparam logic [VW-1:0] LAST_V = VW'(NV - 1);

  scan_state_t        state_q, state_d;
  logic [VW-1:0]      v_q, v_d;
  logic [MW-1:0]      acc_q, acc_d;
  logic [MW-1:0]      mix_q, mix_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic [PHASE_W-1:0] inc_arr  [NV];
  wave_form_t         form_arr [NV];

  logic               en_v;
  logic [PHASE_W-1:0] inc_v;
  wave_form_t         form_v;
  logic [MW-1:0]      acc_sum;

  logic [PHASE_W-1:0] ph_rd;
  logic [PHASE_W-1:0] ph_wr;
  logic               ph_we;

  phase_bank #(
    .NV      (NV),
    .PHASE_W (PHASE_W)
  ) u_phase_bank (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (v_q),
    .rd_data_o (ph_rd),
    .wr_en_i   (ph_we),
    .wr_addr_i (v_q),
    .wr_data_i (ph_wr)
  );

  // Unpack the flattened per-voice configuration buses.
  always_comb begin
    for (int unsigned i = 0; i < NV; i++) begin
      inc_arr[i]  = voice_inc[i*PHASE_W +: PHASE_W];
      form_arr[i] = wave_form_t'(voice_form[i*2 +: 2]);
    end
  end

  // Select the configuration of the voice currently addressed by the scan index.
  always_comb begin
    en_v    = voice_en[v_q];
    inc_v   = inc_arr[v_q];
    form_v  = form_arr[v_q];
    acc_sum = acc_q + MW'(shaper_wave);
  end

  // Scan sequencing, accumulation, phase update and shaper drive.
  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    acc_d       = acc_q;
    mix_d       = mix_q;
    valid_d     = 1'b0;
    ovr_d       = ovr_q;
    ph_we       = 1'b0;
    ph_wr       = '0;
    shaper_saw  = '0;
    shaper_form = OFF;
    busy        = 1'b0;

    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SCAN;
          v_d     = '0;
          acc_d   = '0;
        end
      end

      SCAN: begin
        busy        = 1'b1;
        shaper_saw  = ph_rd[PHASE_W-1 -: SAMPLE_W];
        shaper_form = en_v ? form_v : OFF;

        // A tick during a scan is dropped but remembered as an overrun.
        if (sample_tick) begin
          ovr_d = 1'b1;
        end

        acc_d = acc_sum;
        ph_we = 1'b1;
        ph_wr = en_v ? (ph_rd + inc_v) : '0;

        if (v_q == LAST_V) begin
          state_d = IDLE;
          mix_d   = acc_sum;
          valid_d = 1'b1;
        end else begin
          v_d = v_q + VW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and mix registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q     <= '0;
      acc_q   <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
      mix_q   <= mix_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Registered outputs.
  always_comb begin
    mix_out   = mix_q;
    mix_valid = valid_q;
    overrun   = ovr_q;
  end

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler with a behavioural wave_shaper and
// a voice-level reference model (phase array + per-scan sum).
module tb_voice_scheduler;

  localparam int NV = 4;
  localparam int PW = 16;
  localparam int MW = 8 + $clog2(NV);

  logic              clk;
  logic              rst;
  logic              sample_tick;
  logic [NV-1:0]     voice_en;
  logic [NV*PW-1:0]  voice_inc;
  logic [NV*2-1:0]   voice_form;
  logic [7:0]        shaper_saw;
  logic [1:0]        shaper_form;
  logic [7:0]        shaper_wave;
  logic [MW-1:0]     mix_out;
  logic              mix_valid;
  logic              busy;
  logic              overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PW-1:0] ph_m [NV];
  int            mix_m;
  bit            ovr_m;

  voice_scheduler #(
    .NV      (NV),
    .PHASE_W (PW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .voice_en    (voice_en),
    .voice_inc   (voice_inc),
    .voice_form  (voice_form),
    .shaper_saw  (shaper_saw),
    .shaper_form (shaper_form),
    .shaper_wave (shaper_wave),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural wave_shaper: OFF=0, SQUARE=MSB high/low, SAW=ramp, TRI=fold.
  function automatic logic [7:0] shape(input logic [7:0] s, input logic [1:0] f);
    logic [7:0] dbl;
    dbl = {s[6:0], 1'b0};
    case (f)
      2'b00:   return 8'h00;
      2'b01:   return s[7] ? 8'hFF : 8'h00;
      2'b10:   return s;
      default: return s[7] ? ~dbl : dbl;
    endcase
  endfunction

  always_comb shaper_wave = shape(shaper_saw, shaper_form);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < NV; v++) ph_m[v] = '0;
    mix_m = 0;
    ovr_m = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy",  busy, 0);
      chk("idle_valid", mix_valid, 0);
      chk("idle_saw",   shaper_saw, 0);
      chk("idle_form",  shaper_form, 0);
      chk("idle_mix",   mix_out, mix_m);
      chk("idle_ovr",   overrun, ovr_m);
    end
  endtask

  task automatic do_reset(input int n, input bit with_tick);
    @(posedge clk);
    #1 rst = 1'b1;
    sample_tick = with_tick;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    sample_tick = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_mix",   mix_out, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ovr",   overrun, 0);
    chk("rst_form",  shaper_form, 0);
    idle_cycles(NV + 1);
  endtask

  // One scan. chained: tick already raised by the previous scan's publish cycle.
  // ex_at/rst_at: scan cycle (0..NV-1) in which an extra tick / reset is driven.
  task automatic run_scan(input bit chained, input int ex_at, input int rst_at,
                          input bit chain_out, output int got);
    int            exp_sum;
    logic [PW-1:0] nxt [NV];
    logic [1:0]    f;
    got     = -1;
    exp_sum = 0;
    for (int v = 0; v < NV; v++) begin
      f = voice_form[v*2 +: 2];
      if (voice_en[v]) begin
        exp_sum += int'(shape(ph_m[v][PW-1 -: 8], f));
        nxt[v] = ph_m[v] + voice_inc[v*PW +: PW];
      end else begin
        nxt[v] = '0;
      end
    end

    if (!chained) begin
      @(posedge clk);
      #1 sample_tick = 1'b1;
    end
    @(posedge clk);
    #1 sample_tick = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      chk("scan_busy",  busy, 1);
      chk("scan_valid", mix_valid, 0);
      chk("scan_saw",   shaper_saw, ph_m[k][PW-1 -: 8]);
      chk("scan_form",  shaper_form, voice_en[k] ? voice_form[k*2 +: 2] : 2'b00);
      chk("scan_mix_hold", mix_out, mix_m);
      if (k == ex_at)  sample_tick = 1'b1;
      if (k == rst_at) rst = 1'b1;
      @(posedge clk);
      #1 sample_tick = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < NV + 1; i++) begin
          @(negedge clk);
          chk("abort_busy",  busy, 0);
          chk("abort_valid", mix_valid, 0);
          chk("abort_mix",   mix_out, 0);
          chk("abort_ovr",   overrun, 0);
          chk("abort_saw",   shaper_saw, 0);
        end
        return;
      end
    end

    @(negedge clk);
    for (int v = 0; v < NV; v++) ph_m[v] = nxt[v];
    mix_m = exp_sum;
    if (ex_at >= 0) ovr_m = 1'b1;
    chk("pub_valid", mix_valid, 1);
    chk("pub_mix",   mix_out, exp_sum);
    chk("pub_busy",  busy, 0);
    chk("pub_ovr",   overrun, ovr_m);
    chk("pub_form",  shaper_form, 0);
    got = int'(mix_out);
    if (chain_out) begin
      sample_tick = 1'b1;
    end else begin
      @(negedge clk);
      chk("post_valid", mix_valid, 0);
      chk("post_mix",   mix_out, mix_m);
    end
  endtask

  int got;
  int e3 [4];
  int e4 [3];
  bit pend;
  int ex, rs, mode;
  bit ch;

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    voice_en    = '0;
    voice_inc   = '0;
    voice_form  = '0;
    model_clear();
    e3 = '{0, 0, 255, 255};
    e4 = '{0, 1020, 1016};

    // Reset held for three cycles.
    do_reset(3, 1'b0);

    // Voice 0 alone, SAW ramp.
    voice_en   = 4'b0001;
    voice_inc  = '0;
    voice_inc[15:0] = 16'h0100;
    voice_form = 8'b00_00_00_10;
    for (int i = 0; i < 4; i++) begin
      run_scan(1'b0, -1, -1, 1'b0, got);
      chk("t2_mix", got, i);
      idle_cycles(1);
    end

    // Voice 1 alone, SQUARE at quarter-turn steps.
    do_reset(1, 1'b0);
    voice_en   = 4'b0010;
    voice_inc  = '0;
    voice_inc[31:16] = 16'h4000;
    voice_form = 8'b00_00_01_00;
    for (int i = 0; i < 4; i++) begin
      run_scan(1'b0, -1, -1, 1'b0, got);
      chk("t3_mix", got, e3[i]);
    end

    // All voices SAW near full step: wrap and full-width sum.
    do_reset(1, 1'b0);
    voice_en   = 4'b1111;
    voice_inc  = {4{16'hFF00}};
    voice_form = {4{2'b10}};
    for (int i = 0; i < 3; i++) begin
      run_scan(1'b0, -1, -1, 1'b0, got);
      chk("t4_mix", got, e4[i]);
    end

    // Tick while busy: dropped, overrun sticky.
    do_reset(1, 1'b0);
    run_scan(1'b0, 1, -1, 1'b0, got);
    chk("t5_ovr", overrun, 1);
    idle_cycles(2);
    run_scan(1'b0, -1, -1, 1'b0, got);
    chk("t5_ovr_sticky", overrun, 1);

    // Reset mid-scan, then restart from phase 0.
    do_reset(1, 1'b0);
    voice_en   = 4'b1111;
    voice_inc  = {16'h1234, 16'h2345, 16'h3456, 16'h4567};
    voice_form = 8'b11_10_01_11;
    run_scan(1'b0, -1, -1, 1'b0, got);
    run_scan(1'b0, -1, -1, 1'b0, got);
    run_scan(1'b0, -1, 1, 1'b0, got);
    run_scan(1'b0, -1, -1, 1'b0, got);
    chk("t6_mix_from_zero", got, 0);

    // Tick coincident with reset: no scan starts.
    do_reset(1, 1'b1);

    // Minimum tick spacing: tick in the publish cycle is accepted.
    run_scan(1'b0, -1, -1, 1'b1, got);
    run_scan(1'b1, -1, -1, 1'b0, got);
    chk("min_spacing_no_ovr", overrun, 0);

    // Randomized scans against the reference model.
    pend = 1'b0;
    for (int it = 0; it < 60; it++) begin
      voice_en   = NV'($urandom);
      voice_inc  = {$urandom, $urandom};
      voice_form = 8'($urandom);
      mode = int'($urandom_range(0, 9));
      ex = -1;
      rs = -1;
      if (mode == 0 && !pend)      rs = int'($urandom_range(0, NV - 1));
      else if (mode <= 2)          ex = int'($urandom_range(0, NV - 1));
      ch = (rs < 0) && ($urandom_range(0, 3) == 0);
      run_scan(pend, ex, rs, ch, got);
      pend = ch;
      if (!ch) idle_cycles(int'($urandom_range(0, 3)));
    end
    if (pend) run_scan(1'b1, -1, -1, 1'b0, got);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
